// File: rtl/inst_axi_read_bridge_pkg.sv
// Shared definitions for the instruction-side AXI read bridge and its helpers.
package inst_axi_read_bridge_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned AXI_ID_W = 4;
   localparam int unsigned AXI_LEN_W = 8;
   localparam int unsigned AXI_SIZE_W = 3;
   localparam int unsigned AXI_BURST_W = 2;
   localparam int unsigned AXI_RESP_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2
   } state_e;

   localparam logic [AXI_LEN_W-1:0]   AXI_LEN_SINGLE = 8'd0;
   localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_WORD  = 3'b010;
   localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

   localparam logic [31:0] KSEG01_MASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/inst_axi_read_bridge_vaddr_fixed_map.sv
// Fixed MIPS-style mapping: kseg0/kseg1 fold onto low physical memory, all else passes through.
module vaddr_fixed_map
   import inst_axi_read_bridge_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_vaddr,
   output logic [WIDTH-1:0] o_paddr
);

   logic w_kseg01;

   // Top two address bits 2'b10 select the 0x8000_0000-0xBFFF_FFFF window.
   always_comb begin
      w_kseg01 = (i_vaddr[WIDTH-1 -: 2] == 2'b10);
      o_paddr  = w_kseg01 ? (i_vaddr & WIDTH'(KSEG01_MASK)) : i_vaddr;
   end

endmodule

// File: rtl/inst_axi_read_bridge.sv
// Instruction fetch bridge: one single-beat AXI read per accepted fetch, with flush support.
module inst_axi_read_bridge
   import inst_axi_read_bridge_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter logic [3:0]  ARID_VAL = 4'd0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inst_req,
   input  logic [WIDTH-1:0] inst_addr,
   output logic             inst_addr_ok,
   output logic             inst_data_ok,
   output logic [WIDTH-1:0] inst_rdata,
   output logic             inst_err,
   input  logic             flush,
   output logic [3:0]       arid,
   output logic [WIDTH-1:0] araddr,
   output logic [7:0]       arlen,
   output logic [2:0]       arsize,
   output logic [1:0]       arburst,
   output logic             arvalid,
   input  logic             arready,
   input  logic [3:0]       rid,
   input  logic [WIDTH-1:0] rdata,
   input  logic [1:0]       rresp,
   input  logic             rlast,
   input  logic             rvalid,
   output logic             rready
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic             r_discard;
   logic [WIDTH-1:0] r_araddr;
   logic [WIDTH-1:0] r_inst_rdata;
   logic             r_inst_err;
   logic             r_inst_data_ok;

   logic [WIDTH-1:0] w_paddr;
   logic             w_addr_ok;
   logic             w_accept;
   logic             w_arvalid;
   logic             w_rready;
   logic             w_ar_done;
   logic             w_r_done;
   logic             w_deliver;
   logic             w_unused_rid;

   // Only one read is ever outstanding, so the returned ID carries no information.
   assign w_unused_rid = ^rid;

   vaddr_fixed_map #(
      .WIDTH (WIDTH)
   ) u_vaddr_fixed_map (
      .i_vaddr (inst_addr),
      .o_paddr (w_paddr)
   );

   // State register plus datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_discard      <= 1'b0;
         r_araddr       <= '0;
         r_inst_rdata   <= '0;
         r_inst_err     <= 1'b0;
         r_inst_data_ok <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_inst_data_ok <= w_deliver;
         if (w_accept) begin
            r_araddr  <= w_paddr;
            r_discard <= 1'b0;
         end else if (flush && (r_state != ST_IDLE)) begin
            r_discard <= 1'b1;
         end
         if (w_deliver) begin
            r_inst_rdata <= rdata;
            r_inst_err   <= (rresp != AXI_RESP_OKAY);
         end
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)  w_state_nxt = ST_AR;
         ST_AR:   if (w_ar_done) w_state_nxt = ST_R;
         ST_R:    if (w_r_done)  w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake and strobe decode from current state and inputs.
   always_comb begin
      w_addr_ok = 1'b0;
      w_arvalid = 1'b0;
      w_rready  = 1'b0;
      w_accept  = 1'b0;
      w_ar_done = 1'b0;
      w_r_done  = 1'b0;
      w_deliver = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_addr_ok = ~flush;
            w_accept  = inst_req & ~flush;
         end
         ST_AR: begin
            w_arvalid = 1'b1;
            w_ar_done = arready;
         end
         ST_R: begin
            w_rready  = 1'b1;
            w_r_done  = rvalid & rlast;
            // A flush on the final beat still drops it.
            w_deliver = rvalid & rlast & ~r_discard & ~flush;
         end
         default: ;
      endcase
   end

   assign inst_addr_ok = w_addr_ok;
   assign inst_data_ok = r_inst_data_ok;
   assign inst_rdata   = r_inst_rdata;
   assign inst_err     = r_inst_err;
   assign arid         = ARID_VAL;
   assign araddr       = r_araddr;
   assign arlen        = AXI_LEN_SINGLE;
   assign arsize       = AXI_SIZE_WORD;
   assign arburst      = AXI_BURST_INCR;
   assign arvalid      = w_arvalid;
   assign rready       = w_rready;

endmodule

// File: tb/tb_inst_axi_read_bridge.sv
// Directed, table-driven bench for the instruction-side AXI read bridge.
module tb_inst_axi_read_bridge;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        inst_err;
   logic        flush;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int n_vec;
   int n_err;

   inst_axi_read_bridge #(
      .WIDTH    (32),
      .ARID_VAL (4'd0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .inst_err     (inst_err),
      .flush        (flush),
      .arid         (arid),
      .araddr       (araddr),
      .arlen        (arlen),
      .arsize       (arsize),
      .arburst      (arburst),
      .arvalid      (arvalid),
      .arready      (arready),
      .rid          (rid),
      .rdata        (rdata),
      .rresp        (rresp),
      .rlast        (rlast),
      .rvalid       (rvalid),
      .rready       (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        ok;
      logic        arv;
      logic [31:0] ara;
      logic        rr;
      logic        dok;
      logic [31:0] rd;
      logic        err;
   } out_t;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        fl;
      logic        arr;
      logic        rv;
      logic        rl;
      logic [1:0]  rsp;
      logic [31:0] rdat;
      out_t        exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic fl,
                               input logic arr, input logic rv, input logic rl,
                               input logic [1:0] rsp, input logic [31:0] rdat,
                               input logic e_ok, input logic e_arv, input logic [31:0] e_ara,
                               input logic e_rr, input logic e_dok, input logic [31:0] e_rd,
                               input logic e_err);
      vec_t v;
      v.req  = req;  v.addr = addr; v.fl = fl; v.arr = arr;
      v.rv   = rv;   v.rl   = rl;   v.rsp = rsp; v.rdat = rdat;
      v.exp  = '{ok: e_ok, arv: e_arv, ara: e_ara, rr: e_rr, dok: e_dok, rd: e_rd, err: e_err};
      return v;
   endfunction

   function automatic out_t cur_out();
      return '{ok: inst_addr_ok, arv: arvalid, ara: araddr, rr: rready,
               dok: inst_data_ok, rd: inst_rdata, err: inst_err};
   endfunction

   task automatic drive(input logic req, input logic [31:0] addr, input logic fl,
                        input logic arr, input logic rv, input logic rl,
                        input logic [1:0] rsp, input logic [31:0] rdat);
      inst_req = req; inst_addr = addr; flush = fl; arready = arr;
      rvalid = rv; rlast = rl; rresp = rsp; rdata = rdat;
   endtask

   task automatic idle_in();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
   endtask

   // Compare at the falling edge, then advance to just after the next rising edge.
   task automatic check_step(input string name, input out_t exp);
      out_t act;
      @(negedge clk);
      act = cur_out();
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got ok=%b arv=%b ara=%h rr=%b dok=%b rd=%h err=%b exp ok=%b arv=%b ara=%h rr=%b dok=%b rd=%h err=%b",
                  name, act.ok, act.arv, act.ara, act.rr, act.dok, act.rd, act.err,
                  exp.ok, exp.arv, exp.ara, exp.rr, exp.dok, exp.rd, exp.err);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      rid = 4'd0;
      idle_in();

      // Cycle table: inputs held during the cycle, outputs expected before its rising edge.
      //                  req  addr          fl   arr  rv   rl   rsp    rdata          ok  arv ara           rr  dok rd             err
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h0,        0,0,32'h0,        0));
      vecs.push_back(mk(1'b1, 32'hBFC0_0000,1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h0,        0,0,32'h0,        0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,         0,1,32'h1FC0_0000,0,0,32'h0,        0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b1,1'b1,2'b00,32'h3C08_0001, 0,0,32'h1FC0_0000,1,0,32'h0,        0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h1FC0_0000,0,1,32'h3C08_0001,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h1FC0_0000,0,0,32'h3C08_0001,0));
      // flush one cycle after accept drops the beat
      vecs.push_back(mk(1'b1, 32'h0000_1000,1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h1FC0_0000,0,0,32'h3C08_0001,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b1,1'b0,1'b0,1'b0,2'b00,32'h0,         0,1,32'h0000_1000,0,0,32'h3C08_0001,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,         0,1,32'h0000_1000,0,0,32'h3C08_0001,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b1,1'b1,2'b00,32'hDEAD_BEEF, 0,0,32'h0000_1000,1,0,32'h3C08_0001,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h0000_1000,0,0,32'h3C08_0001,0));
      vecs.push_back(mk(1'b1, 32'h8000_0180,1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h0000_1000,0,0,32'h3C08_0001,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,         0,1,32'h0000_0180,0,0,32'h3C08_0001,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b1,1'b1,2'b00,32'h1234_5678, 0,0,32'h0000_0180,1,0,32'h3C08_0001,0));
      // back-to-back accept during the data_ok pulse
      vecs.push_back(mk(1'b1, 32'hA000_0040,1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h0000_0180,0,1,32'h1234_5678,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,         0,1,32'h0000_0040,0,0,32'h1234_5678,0));
      // flush on the final R handshake
      vecs.push_back(mk(1'b0, 32'h0,        1'b1,1'b0,1'b1,1'b1,2'b00,32'hCAFE_F00D, 0,0,32'h0000_0040,1,0,32'h1234_5678,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h0000_0040,0,0,32'h1234_5678,0));
      // request and flush together in IDLE
      vecs.push_back(mk(1'b1, 32'h9000_0000,1'b1,1'b0,1'b0,1'b0,2'b00,32'h0,         0,0,32'h0000_0040,0,0,32'h1234_5678,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h0000_0040,0,0,32'h1234_5678,0));
      // SLVERR on an unmapped (kseg2) fetch
      vecs.push_back(mk(1'b1, 32'hC000_0010,1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'h0000_0040,0,0,32'h1234_5678,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,         0,1,32'hC000_0010,0,0,32'h1234_5678,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b1,1'b1,2'b10,32'h0BAD_0BAD, 0,0,32'hC000_0010,1,0,32'h1234_5678,0));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'hC000_0010,0,1,32'h0BAD_0BAD,1));
      // stray rvalid in IDLE is ignored
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b1,1'b1,2'b00,32'hFFFF_FFFF, 1,0,32'hC000_0010,0,0,32'h0BAD_0BAD,1));
      vecs.push_back(mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,         1,0,32'hC000_0010,0,0,32'h0BAD_0BAD,1));

      tick();
      tick();
      rst = 1'b0;

      n_vec++;
      if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd0, 3'b010, 2'b01}) begin
         n_err++;
         $display("FAIL ar_consts got id=%h len=%h size=%b burst=%b exp id=0 len=00 size=010 burst=01",
                  arid, arlen, arsize, arburst);
      end

      foreach (vecs[i]) begin
         drive(vecs[i].req, vecs[i].addr, vecs[i].fl, vecs[i].arr,
               vecs[i].rv, vecs[i].rl, vecs[i].rsp, vecs[i].rdat);
         check_step($sformatf("vec%0d", i), vecs[i].exp);
      end

      // AR stall: five cycles with arready low, stray R beats offered meanwhile.
      drive(1'b1, 32'h8000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h5555_AAAA);
         check_step($sformatf("stall%0d", k),
                    '{ok: 1'b0, arv: 1'b1, ara: 32'h0000_0200, rr: 1'b0, dok: 1'b0,
                      rd: 32'h0BAD_0BAD, err: 1'b1});
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
      check_step("stall_hs", '{ok: 1'b0, arv: 1'b1, ara: 32'h0000_0200, rr: 1'b0, dok: 1'b0,
                               rd: 32'h0BAD_0BAD, err: 1'b1});
      idle_in();
      begin : wait_rready
         int cnt;
         cnt = 0;
         while (rready !== 1'b1 && cnt < 10) begin
            tick();
            cnt++;
         end
         if (rready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL stall_rready_timeout got rready=%b exp 1", rready);
         end
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h2400_0007);
      tick();
      idle_in();
      check_step("stall_data", '{ok: 1'b1, arv: 1'b0, ara: 32'h0000_0200, rr: 1'b0, dok: 1'b1,
                                 rd: 32'h2400_0007, err: 1'b0});

      // Reset while waiting in R abandons the fetch.
      drive(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
      tick();
      idle_in();
      check_step("in_r", '{ok: 1'b0, arv: 1'b0, ara: 32'h0000_0300, rr: 1'b1, dok: 1'b0,
                           rd: 32'h2400_0007, err: 1'b0});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_step("post_rst", '{ok: 1'b1, arv: 1'b0, ara: 32'h0, rr: 1'b0, dok: 1'b0,
                               rd: 32'h0, err: 1'b0});
      drive(1'b1, 32'hBFC0_0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
      check_step("fresh_ar", '{ok: 1'b0, arv: 1'b1, ara: 32'h1FC0_0010, rr: 1'b0, dok: 1'b0,
                               rd: 32'h0, err: 1'b0});
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h1111_2222);
      tick();
      idle_in();
      check_step("fresh_data", '{ok: 1'b1, arv: 1'b0, ara: 32'h1FC0_0010, rr: 1'b0, dok: 1'b1,
                                 rd: 32'h1111_2222, err: 1'b0});
      check_step("fresh_pulse_end", '{ok: 1'b1, arv: 1'b0, ara: 32'h1FC0_0010, rr: 1'b0, dok: 1'b0,
                                      rd: 32'h1111_2222, err: 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
